seg_adder: RTL and testbench

Parameterised, pipelined, segmented two's-complement adder/subtractor with a valid/ready handshake. It is the sequential, width-generic successor to the team's single-bit half/full adder cells. Operands are split into SEGS equal slices, one slice per pipeline stage, so the carry chain per cycle is only WIDTH/SEGS bits long. It serves as the arithmetic building block for accumulators and datapath units in later designs.

---
 rtl/seg_adder_if.sv | 26 ++
 rtl/seg_adder.sv | 109 ++++++++++
 tb/tb_seg_adder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_adder_if.sv
// Operand/result handshake bundle for seg_adder: valid/ready in, valid/ready out.
interface seg_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_adder.sv
// Pipelined segmented adder/subtractor: one SEG_W-bit ripple slice per stage,
// operand skew and result deskew handled by per-stage shrinking/growing registers.
module seg_adder #(
  parameter int WIDTH = 16,
  parameter int SEGS  = 4
) (
  input logic       clk,
  input logic       rst,
  seg_adder_if.slave bus
);
  localparam int SEG_W = WIDTH / SEGS;

  logic             w_adv;
  logic             w_xfer;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

  always_comb begin
    w_adv  = !bus.out_valid || bus.out_ready;
    w_xfer = bus.in_valid && w_adv && !rst;
    w_b_in = bus.sub ? ~bus.b : bus.b;
    w_c_in = bus.sub | bus.cin;
  end

  assign bus.in_ready = w_adv && !rst;

  for (genvar s = 0; s < SEGS; s++) begin : g_st
    // PW: operand bits still to be consumed entering this stage; DW: result bits done after it.
    localparam int PW = WIDTH - s * SEG_W;
    localparam int RW = PW - SEG_W;
    localparam int DW = (s + 1) * SEG_W;

    logic [PW-1:0]    w_pa;
    logic [PW-1:0]    w_pb;
    logic             w_ci;
    logic             w_vin;
    logic [SEG_W-1:0] w_sl;
    logic             w_co;
    logic             r_vld;
    logic             r_cy;
    logic [DW-1:0]    r_sum;

    assign {w_co, w_sl} = {1'b0, w_pa[SEG_W-1:0]} + {1'b0, w_pb[SEG_W-1:0]}
                        + (SEG_W + 1)'(w_ci);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vin;
        r_cy  <= w_co;
      end
    end

    if (s == 0) begin : g_src
      assign w_pa  = bus.a;
      assign w_pb  = w_b_in;
      assign w_ci  = w_c_in;
      assign w_vin = w_xfer;

      always_ff @(posedge clk) begin
        if (rst)        r_sum <= '0;
        else if (w_adv) r_sum <= w_sl;
      end
    end else begin : g_src
      assign w_pa  = g_st[s-1].g_rem.r_a;
      assign w_pb  = g_st[s-1].g_rem.r_b;
      assign w_ci  = g_st[s-1].r_cy;
      assign w_vin = g_st[s-1].r_vld;

      // New slice lands above the slices finished by earlier stages.
      always_ff @(posedge clk) begin
        if (rst)        r_sum <= '0;
        else if (w_adv) r_sum <= {w_sl, g_st[s-1].r_sum};
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_pa[PW-1:SEG_W];
          r_b <= w_pb[PW-1:SEG_W];
        end
      end
    end

    if (s == SEGS - 1) begin : g_last
      logic r_ovf;

      // a^b^sum at the MSB recovers the carry into the MSB inside this slice.
      always_ff @(posedge clk) begin
        if (rst)        r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_co ^ w_pa[SEG_W-1] ^ w_pb[SEG_W-1] ^ w_sl[SEG_W-1];
      end
    end
  end

  assign bus.out_valid = g_st[SEGS-1].r_vld;
  assign bus.sum       = g_st[SEGS-1].r_sum;
  assign bus.cout      = g_st[SEGS-1].r_cy;
  assign bus.ovf       = g_st[SEGS-1].g_last.r_ovf;
endmodule

// File: tb/tb_seg_adder.sv
// Directed bench for seg_adder (16/4) plus randomized reference sweeps on (8,1), (8,8), (32,4).
module tb_seg_adder;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [33:0] e;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  seg_adder_if #(.WIDTH(16)) bus ();
  seg_adder_if #(.WIDTH(8))  bus81 ();
  seg_adder_if #(.WIDTH(8))  bus88 ();
  seg_adder_if #(.WIDTH(32)) bus324 ();

  seg_adder #(.WIDTH(16), .SEGS(4)) dut     (.clk(clk), .rst(rst), .bus(bus));
  seg_adder #(.WIDTH(8),  .SEGS(1)) dut8_1  (.clk(clk), .rst(rst), .bus(bus81));
  seg_adder #(.WIDTH(8),  .SEGS(8)) dut8_8  (.clk(clk), .rst(rst), .bus(bus88));
  seg_adder #(.WIDTH(32), .SEGS(4)) dut32_4 (.clk(clk), .rst(rst), .bus(bus324));

  // Reference: {ovf, cout, sum} for a w-bit add/sub.
  function automatic logic [33:0] model(int unsigned w, logic [31:0] a, logic [31:0] b,
                                        logic cin, logic sub);
    logic [63:0] mask, m1, aa, bb, cc, full, low;
    mask = (64'd1 << w) - 64'd1;
    m1   = (64'd1 << (w - 1)) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    cc   = sub ? 64'd1 : {63'd0, cin};
    full = aa + bb + cc;
    low  = (aa & m1) + (bb & m1) + cc;
    return {low[w-1] ^ full[w], full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic run_single(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, output logic [15:0] s, output logic co,
                            output logic ov, output int lat);
    int acc;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = ~cin; bus.sub = ~sub;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) begin
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
    end
    s = bus.sum; co = bus.cout; ov = bus.ovf;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus81.in_valid = 1'b0; bus81.out_ready = 1'b1; bus81.a = '0; bus81.b = '0; bus81.cin = 1'b0; bus81.sub = 1'b0;
    bus88.in_valid = 1'b0; bus88.out_ready = 1'b1; bus88.a = '0; bus88.b = '0; bus88.cin = 1'b0; bus88.sub = 1'b0;
    bus324.in_valid = 1'b0; bus324.out_ready = 1'b1; bus324.a = '0; bus324.b = '0; bus324.cin = 1'b0; bus324.sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state got vld=%b sum=%h cout=%b ovf=%b in_ready=%b want all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_arith;
    logic [15:0] ta [4]   = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005};
    logic [15:0] tb_ [4]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0007};
    logic        tcin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        tsub [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [17:0] texp [4] = '{{16'h0000, 2'b10}, {16'h8000, 2'b01},
                              {16'h7FFF, 2'b11}, {16'hFFFE, 2'b00}};
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_single(ta[i], tb_[i], tcin[i], tsub[i], s, co, ov, lat);
      checks++;
      if ({s, co, ov} !== texp[i]) begin
        errors++;
        $display("FAIL arith_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, s, co, ov, texp[i][17:2], texp[i][1], texp[i][0]);
      end
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL arith_latency_%0d got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic        pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int          n_in = 0;
    int          n_out = 0;
    int          c = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_o = '0;
    logic [15:0] ev;
    logic        exp_rdy;
    while (n_out < 8 && c < 80) begin
      @(negedge clk);
      bus.out_ready = pat[c % 8];
      #1;
      exp_rdy = !(bus.out_valid && !bus.out_ready);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready cycle %0d got %b want %b", c, bus.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, prev_o}) begin
          errors++;
          $display("FAIL b2b_stall_hold cycle %0d got vld=%b out=%h want vld=1 out=%h",
                   c, bus.out_valid, {bus.sum, bus.cout, bus.ovf}, prev_o);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        ev = 16'(n_out) + 16'(n_out * 256) + 16'(n_out & 1);
        checks++;
        if ({bus.sum, bus.cout, bus.ovf} !== {ev, 2'b00}) begin
          errors++;
          $display("FAIL b2b_result_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=0 ovf=0",
                   n_out, bus.sum, bus.cout, bus.ovf, ev);
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_o = {bus.sum, bus.cout, bus.ovf};
      if (n_in < 8) begin
        bus.in_valid = 1'b1; bus.a = 16'(n_in); bus.b = 16'(n_in * 256);
        bus.cin = 1'(n_in & 1); bus.sub = 1'b0;
        if (bus.in_ready) n_in++;
      end else begin
        bus.in_valid = 1'b0;
      end
      c++;
    end
    checks++;
    if (n_out != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d want 8", n_out);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_extra_result got out_valid=%b sum=%h want out_valid=0", bus.out_valid, bus.sum);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    bus.out_ready = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 16'(16'h1111 * (i + 1)); bus.b = 16'h0101;
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a = 16'h4321; bus.b = 16'h1234;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== 20'd0) begin
      errors++;
      $display("FAIL midrst_state got vld=%b sum=%h cout=%b ovf=%b in_ready=%b want all 0",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale cycle %0d got out_valid=%b sum=%h want out_valid=0", k, bus.out_valid, bus.sum);
      end
    end
    run_single(16'h0002, 16'h0003, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'h0005, 2'b00} || lat != 4) begin
      errors++;
      $display("FAIL midrst_new_op got sum=%h cout=%b ovf=%b lat=%0d want sum=0005 cout=0 ovf=0 lat=4",
               s, co, ov, lat);
    end
  endtask

  task automatic test_sweep;
    int          issued = 0;
    int          c = 0;
    logic [31:0] ra, rb;
    logic        rc, rs;
    exp_t        x;
    while ((issued < 1000 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && c < 4000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic        v, co, ov, empty;
        logic [31:0] s;
        int          segs;
        case (k)
          0:       begin v = bus81.out_valid;  s = {24'd0, bus81.sum}; co = bus81.cout;  ov = bus81.ovf;  segs = 1; empty = (q0.size() == 0); end
          1:       begin v = bus88.out_valid;  s = {24'd0, bus88.sum}; co = bus88.cout;  ov = bus88.ovf;  segs = 8; empty = (q1.size() == 0); end
          default: begin v = bus324.out_valid; s = bus324.sum;         co = bus324.cout; ov = bus324.ovf; segs = 4; empty = (q2.size() == 0); end
        endcase
        if (v) begin
          checks++;
          if (empty) begin
            errors++;
            $display("FAIL sweep_extra cfg %0d got out_valid=1 sum=%h want no result", k, s);
          end else begin
            case (k)
              0:       x = q0.pop_front();
              1:       x = q1.pop_front();
              default: x = q2.pop_front();
            endcase
            if ({ov, co, s} !== x.e || (cyc - x.acc) != segs) begin
              errors++;
              $display("FAIL sweep_result cfg %0d got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=%0d",
                       k, s, co, ov, cyc - x.acc, x.e[31:0], x.e[32], x.e[33], segs);
            end
          end
        end
      end
      if (issued < 1000 && $urandom_range(0, 4) != 0) begin
        checks++;
        if ({bus81.in_ready, bus88.in_ready, bus324.in_ready} !== 3'b111) begin
          errors++;
          $display("FAIL sweep_in_ready got %b want 111", {bus81.in_ready, bus88.in_ready, bus324.in_ready});
        end
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
        bus81.a  = ra[7:0]; bus81.b  = rb[7:0]; bus81.cin  = rc; bus81.sub  = rs; bus81.in_valid  = 1'b1;
        bus88.a  = ra[7:0]; bus88.b  = rb[7:0]; bus88.cin  = rc; bus88.sub  = rs; bus88.in_valid  = 1'b1;
        bus324.a = ra;      bus324.b = rb;      bus324.cin = rc; bus324.sub = rs; bus324.in_valid = 1'b1;
        x.acc = cyc;
        x.e = model(8, ra, rb, rc, rs);  q0.push_back(x);
        q1.push_back(x);
        x.e = model(32, ra, rb, rc, rs); q2.push_back(x);
        issued++;
      end else begin
        bus81.in_valid = 1'b0; bus88.in_valid = 1'b0; bus324.in_valid = 1'b0;
      end
      c++;
    end
    checks++;
    if (issued != 1000 || q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL sweep_drain got issued=%0d pending=%0d/%0d/%0d want 1000 and 0/0/0",
               issued, q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
